// File: rtl/clk_rate_pkg.sv
// rtl/clk_rate_pkg.sv - shared types and period helpers for the clock-rate decoder
package clk_rate_pkg;

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } state_e;

    localparam int NUM_CODES        = 4;
    localparam int TIMEOUT_LOG2_OFS = 4;

    function automatic longint unsigned nominal_period(input int base_log2, input int k);
        return 64'd1 << (base_log2 + k);
    endfunction

    // Longer than the slowest code's period by 2x, so a live clock never trips it.
    function automatic longint unsigned timeout_cycles(input int base_log2);
        return 64'd1 << (base_log2 + TIMEOUT_LOG2_OFS);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with registered rising-edge detect
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign edge_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/clk_rate_decoder.sv
// rtl/clk_rate_decoder.sv - measures divided-clock period, decodes divide select, reports lock
module clk_rate_decoder
    import clk_rate_pkg::*;
#(
    parameter int BASE_LOG2 = 22,
    parameter int TOL       = 16,
    parameter int LOCK_CNT  = 2,
    parameter int CNT_W     = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [1:0]       n_dec,
    output logic             locked,
    output logic             no_clk
);

    localparam int DW   = CNT_W + 1;
    localparam int MC_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(timeout_cycles(BASE_LOG2) - 64'd1);
    localparam logic [MC_W-1:0]      LOCK_TGT     = MC_W'(LOCK_CNT);
    localparam logic signed [DW-1:0] TOL_S        = DW'(TOL);

    logic edge_det;

    sync_edge_det u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (clk_in),
        .edge_pulse (edge_det)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic [1:0]       n_dec_q, n_dec_d;
    logic             locked_q, locked_d;
    logic             no_clk_q, no_clk_d;
    logic [1:0]       cand_q, cand_d;
    logic [MC_W-1:0]  mc_q, mc_d;

    logic [CNT_W-1:0] meas_len;
    logic             timeout_hit;
    logic             match_any;
    logic [1:0]       match_code;

    // Signed, one bit wider than the counter so the difference cannot wrap.
    function automatic logic within_tol(input logic [CNT_W-1:0] p, input int k);
        logic signed [DW-1:0] d;
        d = $signed({1'b0, p}) - $signed(DW'(nominal_period(BASE_LOG2, k)));
        return (d >= -TOL_S) && (d <= TOL_S);
    endfunction

    assign meas_len    = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    // Walk from the slowest code down so the lowest matching code wins.
    always_comb begin
        match_any  = 1'b0;
        match_code = 2'd0;
        for (int k = NUM_CODES - 1; k >= 0; k--) begin
            if (within_tol(meas_len, k)) begin
                match_any  = 1'b1;
                match_code = 2'(k);
            end
        end
    end

    always_comb begin
        if (edge_det) begin
            cnt_d = '0;
        end else if (timeout_hit) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (edge_det) state_d = MEASURE;
            MEASURE: if (!edge_det && timeout_hit) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        period_d = period_q;
        pv_d     = 1'b0;
        n_dec_d  = n_dec_q;
        locked_d = locked_q;
        no_clk_d = no_clk_q;
        cand_d   = cand_q;
        mc_d     = mc_q;
        if (state_q == MEASURE) begin
            if (edge_det) begin
                period_d = meas_len;
                pv_d     = 1'b1;
                no_clk_d = 1'b0;
                if (!match_any) begin
                    mc_d = '0;
                end else if (match_code == cand_q) begin
                    mc_d = (mc_q == LOCK_TGT) ? mc_q : mc_q + MC_W'(1);
                end else begin
                    cand_d = match_code;
                    mc_d   = MC_W'(1);
                end
                locked_d = (mc_d == LOCK_TGT);
                // n_dec only moves on a lock rise, so it keeps the last good code while unlocked.
                if (locked_d && !locked_q) begin
                    n_dec_d = cand_d;
                end
            end else if (timeout_hit) begin
                no_clk_d = 1'b1;
                locked_d = 1'b0;
                mc_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            n_dec_q  <= 2'd0;
            locked_q <= 1'b0;
            no_clk_q <= 1'b0;
            cand_q   <= 2'd0;
            mc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            n_dec_q  <= n_dec_d;
            locked_q <= locked_d;
            no_clk_q <= no_clk_d;
            cand_q   <= cand_d;
            mc_q     <= mc_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign n_dec        = n_dec_q;
    assign locked       = locked_q;
    assign no_clk       = no_clk_q;

endmodule

// File: tb/tb_clk_rate_decoder.sv
// tb/tb_clk_rate_decoder.sv - randomized self-checking bench with timestamp-based reference model
module tb_clk_rate_decoder;

    localparam int B   = 4;
    localparam int TOL = 2;
    localparam int LK  = 2;
    localparam int CW  = 9;
    localparam int TMO = 256;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          clk_in = 1'b0;
    logic [CW-1:0] period;
    logic          period_valid;
    logic [1:0]    n_dec;
    logic          locked;
    logic          no_clk;

    int n_vec = 0;
    int n_err = 0;
    int ph    = 2;

    always #5 clk = ~clk;

    clk_rate_decoder #(
        .BASE_LOG2 (B),
        .TOL       (TOL),
        .LOCK_CNT  (LK),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_in       (clk_in),
        .period       (period),
        .period_valid (period_valid),
        .n_dec        (n_dec),
        .locked       (locked),
        .no_clk       (no_clk)
    );

    bit samp_q[$] = {1'b0, 1'b0, 1'b0};
    int cyc       = 0;
    int last_edge = 0;
    bit meas      = 0;
    int m_period  = 0;
    bit m_pv      = 0;
    int m_ndec    = 0;
    bit m_locked  = 0;
    bit m_noclk   = 0;
    int cand      = 0;
    int mc        = 0;

    function automatic int classify(input int p);
        for (int k = 0; k < 4; k++) begin
            int nom;
            nom = 1 << (B + k);
            if ((p - nom <= TOL) && (nom - p <= TOL)) return k;
        end
        return -1;
    endfunction

    // Edges are time stamps: clk_in sampled at posedge i becomes a detected rise at posedge i+2.
    always @(posedge clk or negedge rst_n) begin : model_p
        bit e;
        int p;
        int k;
        if (!rst_n) begin
            samp_q   = {1'b0, 1'b0, 1'b0};
            cyc      = 0;
            last_edge = 0;
            meas     = 0;
            m_period = 0;
            m_pv     = 0;
            m_ndec   = 0;
            m_locked = 0;
            m_noclk  = 0;
            cand     = 0;
            mc       = 0;
        end else begin
            cyc  = cyc + 1;
            e    = samp_q[1] && !samp_q[0];
            m_pv = 0;
            if (e) begin
                if (meas) begin
                    p        = cyc - last_edge;
                    m_period = p;
                    m_pv     = 1;
                    m_noclk  = 0;
                    k        = classify(p);
                    if (k < 0) mc = 0;
                    else if (k == cand) mc = (mc < LK) ? mc + 1 : LK;
                    else begin
                        cand = k;
                        mc   = 1;
                    end
                    if (mc == LK && !m_locked) m_ndec = cand;
                    m_locked = (mc == LK);
                end
                meas      = 1;
                last_edge = cyc;
            end else if (meas && (cyc - last_edge == TMO)) begin
                m_noclk  = 1;
                m_locked = 0;
                mc       = 0;
                meas     = 0;
            end
            samp_q.push_back(clk_in);
            void'(samp_q.pop_front());
        end
    end

    int pv_total    = 0;
    int since_pv    = 0;
    int noclk_delay = -1;
    bit noclk_prev  = 0;

    always @(negedge clk) begin
        n_vec = n_vec + 1;
        if (period !== m_period[CW-1:0] || period_valid !== m_pv || n_dec !== m_ndec[1:0]
            || locked !== m_locked || no_clk !== m_noclk) begin
            n_err = n_err + 1;
            $display("FAIL cycle_cmp t=%0t: got period=%0d pv=%0b n_dec=%0d locked=%0b no_clk=%0b, want period=%0d pv=%0b n_dec=%0d locked=%0b no_clk=%0b",
                     $time, period, period_valid, n_dec, locked, no_clk,
                     m_period, m_pv, m_ndec, m_locked, m_noclk);
        end
        if (period_valid === 1'b1) begin
            pv_total = pv_total + 1;
            since_pv = 0;
        end else begin
            since_pv = since_pv + 1;
        end
        if (no_clk === 1'b1 && !noclk_prev) noclk_delay = since_pv;
        noclk_prev = (no_clk === 1'b1);
    end

    task automatic chk(input string name, input int got, input int exp);
        n_vec = n_vec + 1;
        if (got != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input bit lvl, input int cycles);
        clk_in = lvl;
        repeat (cycles) @(posedge clk);
        #(ph);
    endtask

    task automatic gen(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, p / 2);
            drive(1'b0, p - p / 2);
        end
    endtask

    initial begin : watchdog
        #900000;
        n_err = n_err + 1;
        $display("FAIL watchdog: time %0t reached, required finish before 900000", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin : main
        int snap;
        int sel;
        int p;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_period", int'(period), 0);
        chk("reset_pv", int'(period_valid), 0);
        chk("reset_n_dec", int'(n_dec), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_no_clk", int'(no_clk), 0);
        rst_n = 1'b1;
        drive(1'b0, 4);

        snap = pv_total;
        gen(16, 5);
        chk("p16_pv_count", pv_total - snap, 4);
        chk("p16_period", int'(period), 16);
        chk("p16_locked", int'(locked), 1);
        chk("p16_n_dec", int'(n_dec), 0);
        chk("p16_no_clk", int'(no_clk), 0);

        gen(64, 3);
        chk("p64_locked", int'(locked), 1);
        chk("p64_n_dec", int'(n_dec), 2);
        chk("p64_period", int'(period), 64);
        gen(128, 1);
        chk("p128a_locked", int'(locked), 1);
        chk("p128a_n_dec", int'(n_dec), 2);
        gen(128, 1);
        chk("p128b_period", int'(period), 128);
        chk("p128b_locked", int'(locked), 0);
        chk("p128b_n_dec", int'(n_dec), 2);
        gen(128, 1);
        chk("p128c_locked", int'(locked), 1);
        chk("p128c_n_dec", int'(n_dec), 3);

        gen(24, 3);
        chk("p24_period", int'(period), 24);
        chk("p24_locked", int'(locked), 0);
        chk("p24_n_dec", int'(n_dec), 3);

        gen(16, 3);
        chk("relock_locked", int'(locked), 1);
        chk("relock_n_dec", int'(n_dec), 0);
        drive(1'b0, 300);
        chk("tmo_no_clk", int'(no_clk), 1);
        chk("tmo_locked", int'(locked), 0);
        chk("tmo_delay", noclk_delay, 256);
        snap = pv_total;
        gen(16, 2);
        chk("search_pv_count", pv_total - snap, 1);
        chk("search_period", int'(period), 16);
        chk("search_no_clk", int'(no_clk), 0);

        gen(16, 2);
        gen(256, 1);
        gen(16, 1);
        chk("coinc_period", int'(period), 256);
        chk("coinc_no_clk", int'(no_clk), 0);
        chk("coinc_locked", int'(locked), 0);

        gen(16, 3);
        chk("prerst_locked", int'(locked), 1);
        drive(1'b1, 4);
        rst_n = 1'b0;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_pv", int'(period_valid), 0);
        chk("arst_n_dec", int'(n_dec), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_no_clk", int'(no_clk), 0);
        drive(1'b0, 3);
        rst_n = 1'b1;
        drive(1'b0, 8);
        snap = pv_total;
        gen(16, 3);
        chk("postrst_pv_count", pv_total - snap, 2);
        chk("postrst_locked", int'(locked), 1);

        for (int s = 0; s < 30; s++) begin
            ph  = int'($urandom_range(1, 4));
            sel = int'($urandom_range(0, 7));
            if (sel < 4) begin
                p = (16 << sel) + int'($urandom_range(0, 8)) - 4;
                gen(p, int'($urandom_range(1, 4)));
            end else if (sel < 6) begin
                gen(int'($urandom_range(2, 280)), int'($urandom_range(1, 3)));
            end else if (sel == 6) begin
                drive(1'b0, int'($urandom_range(200, 300)));
            end else begin
                rst_n = 1'b0;
                drive(1'b0, int'($urandom_range(1, 3)));
                rst_n = 1'b1;
            end
        end
        drive(1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
